fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register; sits directly upstream of the decode stage.
- Owns the PC and drives the instruction SRAM-like interface: req/addr_ok/data_ok, at most one request outstanding.
- Applies the taken-branch redirect reported by decode after the delay slot has been fetched.
- Applies exception flush redirects.
- Presents pc/inst/valid/address-error to decode.

Parameters:
- RESET_PC, 32'hBFC00000, PC loaded on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- stall  input  1  hazard unit: hold the IF/ID register and PC.
- flush  input  1  exception/eret redirect; highest priority.
- flush_pc  input  32  redirect target used when flush=1.
- branch  input  1  decode: instruction in ID is a taken branch/jump.
- branch_addr  input  32  decode: branch target.
- inst_req  output  1  fetch request valid.
- inst_addr  output  32  fetch address; always equals the PC register.
- inst_addr_ok  input  1  request accepted this cycle.
- inst_data_ok  input  1  read data valid this cycle.
- inst_rdata  input  32  instruction word.
- id_pc  output  32  PC of the instruction in ID.
- id_inst  output  32  instruction in ID; 0 (nop) when invalid.
- id_valid  output  1  ID holds a real instruction.
- id_adel  output  1  ID instruction had a misaligned fetch address.

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC; state=S_REQ.
  - id_pc=0, id_inst=0, id_valid=0, id_adel=0.
  - redir_valid=0, buffer cleared.
  - inst_req=0 in the reset cycle; rst overrides all other inputs.
- States:
  - S_REQ:
    - pc[1:0]!=0: no request; load buffer with inst=0, adel=1; go to S_DONE.
    - Otherwise inst_req=1. On inst_addr_ok go to S_WAIT.
  - S_WAIT: inst_req=0. On inst_data_ok capture inst_rdata, adel=0; go to S_DONE. data_ok is never expected in the same cycle as addr_ok.
  - S_DONE: buffer valid, inst_req=0. Advances when stall=0; then pc<=next_pc and go to S_REQ. The next request is issued the following cycle.
  - S_DROP: in-flight request cancelled by flush. inst_req=0. On inst_data_ok discard the data and go to S_REQ.
- IF/ID register:
  - Updates only when stall=0.
  - In S_DONE it loads id_pc=pc and the buffered inst/adel, with id_valid=1.
  - In any other state it loads a bubble: id_valid=0, id_inst=0, id_adel=0, id_pc unchanged.
- Branch:
  - branch_take = branch & id_valid & ~stall.
  - On branch_take, pc already points at the delay slot. The target is applied when the delay slot advances out of S_DONE.
  - If the delay slot advances in the same cycle as branch_take: next_pc=branch_addr.
  - Otherwise: redir_valid<=1, redir_addr<=branch_addr.
  - next_pc = redir_valid ? redir_addr : branch_take ? branch_addr : pc+4.
  - redir_valid clears whenever pc is updated from next_pc.
  - The delay slot is always delivered to ID.
  - pc+4 wraps modulo 2^32.
- Flush (overrides stall and branch):
  - pc<=flush_pc, redir_valid<=0.
  - IF/ID register loads a bubble.
  - Next state by current state:
    - S_REQ with addr_ok this cycle: S_DROP.
    - S_REQ without addr_ok: S_REQ; the new address is driven next cycle, which is legal because the old request was not accepted.
    - S_WAIT without data_ok: S_DROP.
    - S_WAIT with data_ok: S_REQ.
    - S_DONE: S_REQ, buffer dropped.
    - S_DROP: stays S_DROP, or S_REQ if data_ok this cycle.
- Stall with S_DONE: buffer, pc and outputs hold indefinitely. No new request is issued.

Test Plan:
- Reset then memory with addr_ok immediate and data_ok one cycle later, no stall:
  - First inst_addr=BFC00000.
  - id_valid pulses with id_pc BFC00000, BFC00004, ... every 3 cycles.
  - Bubbles between them have id_inst=0.
- Branch at BFC00000 with branch=1 and branch_addr=BFC00100 while ID holds it:
  - Delay slot BFC00004 still reaches ID.
  - Next inst_addr=BFC00100.
  - Repeat with the delay slot in S_DONE in the same cycle as branch_take: same sequence.
- stall=1 for 5 cycles while in S_DONE with the buffer holding 0x24020005:
  - id_* frozen and inst_req=0.
  - After release, ID gets 0x24020005 exactly once.
- flush=1 with flush_pc=BFC00380 while in S_WAIT:
  - Late data_ok data (0xDEADBEEF) never appears on id_inst.
  - Next inst_addr=BFC00380.
  - redir_valid cleared even if a branch was pending.
- flush to 0x80000002 (misaligned):
  - No inst_req.
  - ID receives id_pc=80000002, id_adel=1, id_inst=0, id_valid=1.
- rst asserted while in S_WAIT:
  - Outputs return to reset values next edge.
  - inst_addr=RESET_PC thereafter.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage and IF/ID pipeline register.
// Single-outstanding SRAM-like fetch, delay-slot-aware branch redirect, flush redirect.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic        branch,
   input  logic [31:0] branch_addr,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic        id_valid,
   output logic        id_adel
);

   typedef enum logic [1:0] {StReq, StWait, StDone, StDrop} state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic        redir_valid_q;
   logic [31:0] redir_addr_q;
   logic [31:0] buf_inst_q;
   logic        buf_adel_q;
   logic [31:0] id_pc_q;
   logic [31:0] id_inst_q;
   logic        id_valid_q;
   logic        id_adel_q;

   logic        misaligned;
   logic        req_fire;
   logic        branch_take;
   logic        advance;
   logic [31:0] next_pc;

   assign misaligned  = (pc_q[1:0] != 2'b00);
   assign inst_req    = ~rst & (state_q == StReq) & ~misaligned;
   assign inst_addr   = pc_q;
   assign req_fire    = inst_req & inst_addr_ok;
   assign branch_take = branch & id_valid_q & ~stall;
   assign advance     = (state_q == StDone) & ~stall;
   assign next_pc     = redir_valid_q ? redir_addr_q :
                        branch_take   ? branch_addr  : pc_q + 32'd4;

   assign id_pc    = id_pc_q;
   assign id_inst  = id_inst_q;
   assign id_valid = id_valid_q;
   assign id_adel  = id_adel_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StReq;
         pc_q          <= RESET_PC;
         redir_valid_q <= 1'b0;
         redir_addr_q  <= '0;
         buf_inst_q    <= '0;
         buf_adel_q    <= 1'b0;
         id_pc_q       <= '0;
         id_inst_q     <= '0;
         id_valid_q    <= 1'b0;
         id_adel_q     <= 1'b0;
      end else if (flush) begin
         pc_q          <= flush_pc;
         redir_valid_q <= 1'b0;
         id_inst_q     <= '0;
         id_valid_q    <= 1'b0;
         id_adel_q     <= 1'b0;
         // An accepted-but-unreturned request must be drained before refetching.
         unique case (state_q)
            StReq:   state_q <= req_fire ? StDrop : StReq;
            StWait:  state_q <= inst_data_ok ? StReq : StDrop;
            StDone:  state_q <= StReq;
            StDrop:  state_q <= inst_data_ok ? StReq : StDrop;
            default: state_q <= StReq;
         endcase
      end else begin
         if (!stall) begin
            if (advance) begin
               id_pc_q    <= pc_q;
               id_inst_q  <= buf_inst_q;
               id_adel_q  <= buf_adel_q;
               id_valid_q <= 1'b1;
            end else begin
               id_inst_q  <= '0;
               id_adel_q  <= 1'b0;
               id_valid_q <= 1'b0;
            end
         end

         // The branch target takes effect only once the delay slot leaves the buffer.
         if (advance) begin
            pc_q          <= next_pc;
            redir_valid_q <= 1'b0;
         end else if (branch_take) begin
            redir_valid_q <= 1'b1;
            redir_addr_q  <= branch_addr;
         end

         unique case (state_q)
            StReq: begin
               if (misaligned) begin
                  buf_inst_q <= '0;
                  buf_adel_q <= 1'b1;
                  state_q    <= StDone;
               end else if (req_fire) begin
                  state_q <= StWait;
               end
            end
            StWait: begin
               if (inst_data_ok) begin
                  buf_inst_q <= inst_rdata;
                  buf_adel_q <= 1'b0;
                  state_q    <= StDone;
               end
            end
            StDone: begin
               if (advance) state_q <= StReq;
            end
            StDrop: begin
               if (inst_data_ok) state_q <= StReq;
            end
            default: state_q <= StReq;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a memory responder checks fetch addresses against an
// expected-address queue, and every new IF/ID load is popped against an expected-ID queue.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'hBFC00000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
   } id_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] flush_pc = '0;
   logic        branch = 1'b0;
   logic [31:0] branch_addr = '0;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok = 1'b0;
   logic        inst_data_ok = 1'b0;
   logic [31:0] inst_rdata = '0;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_valid;
   logic        id_adel;

   id_t         exp_id[$];
   logic [31:0] exp_addr[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          last_valid = -1;
   bit          pend = 0;
   bit          hold_data = 0;
   bit          force_rdata = 0;
   bit          check_gap = 0;
   bit          addr_ok_en = 1;
   logic [31:0] pend_addr = '0;

   fetch_stage #(.RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .flush        (flush),
      .flush_pc     (flush_pc),
      .branch       (branch),
      .branch_addr  (branch_addr),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .id_pc        (id_pc),
      .id_inst      (id_inst),
      .id_valid     (id_valid),
      .id_adel      (id_adel)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running, required to finish");
      $fatal(1);
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h24020005 + {20'd0, a[13:2]};
   endfunction

   task automatic push_fetch(input logic [31:0] a);
      exp_addr.push_back(a);
      exp_id.push_back({a, mem_word(a), 1'b0});
   endtask

   // Drive memory inputs for the coming edge and check any request it will accept.
   task automatic mem_drive();
      logic [31:0] e;
      inst_data_ok = pend && !hold_data;
      inst_rdata   = force_rdata ? 32'hDEADBEEF : (pend ? mem_word(pend_addr) : 32'h0);
      if (inst_data_ok) pend = 0;
      inst_addr_ok = addr_ok_en;
      if (inst_req && inst_addr_ok) begin
         n_vec++;
         if (exp_addr.size() == 0) begin
            n_err++;
            $display("FAIL fetch_addr: unexpected request at %h, required none", inst_addr);
         end else begin
            e = exp_addr.pop_front();
            if (inst_addr !== e) begin
               n_err++;
               $display("FAIL fetch_addr: got %h, required %h", inst_addr, e);
            end
         end
         pend      = 1;
         pend_addr = inst_addr;
      end
   endtask

   task automatic tick();
      bit  held;
      id_t e;
      #2;
      mem_drive();
      held = stall | rst | flush;
      @(posedge clk);
      #1;
      cyc++;
      if (!held && id_valid) begin
         n_vec++;
         if (exp_id.size() == 0) begin
            n_err++;
            $display("FAIL id_out: unexpected valid pc=%h inst=%h, required none", id_pc, id_inst);
         end else begin
            e = exp_id.pop_front();
            if ({id_pc, id_inst, id_adel} !== e) begin
               n_err++;
               $display("FAIL id_out: got pc=%h inst=%h adel=%b, required pc=%h inst=%h adel=%b",
                        id_pc, id_inst, id_adel, e.pc, e.inst, e.adel);
            end
         end
         if (check_gap && last_valid >= 0) begin
            n_vec++;
            if (cyc - last_valid != 3) begin
               n_err++;
               $display("FAIL id_spacing: got %0d cycles, required 3", cyc - last_valid);
            end
         end
         last_valid = cyc;
      end else if (!id_valid) begin
         n_vec++;
         if (id_inst !== 32'h0) begin
            n_err++;
            $display("FAIL bubble_inst: got %h, required 00000000", id_inst);
         end
      end
   endtask

   task automatic run_drain(input int budget);
      int n = 0;
      while (exp_id.size() > 0 && n < budget) begin
         tick();
         n++;
      end
      n_vec++;
      if (exp_id.size() != 0 || exp_addr.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d id and %0d addr entries left, required 0 and 0",
                  exp_id.size(), exp_addr.size());
         exp_id.delete();
         exp_addr.delete();
      end
   endtask

   task automatic do_reset();
      rst = 1; stall = 0; flush = 0; branch = 0; flush_pc = '0; branch_addr = '0;
      hold_data = 0; force_rdata = 0; addr_ok_en = 1; check_gap = 0;
      pend = 0;
      exp_id.delete();
      exp_addr.delete();
      tick();
      tick();
      rst = 0;
      last_valid = -1;
   endtask

   task automatic wait_id_valid();
      for (int i = 0; i < 10 && !id_valid; i++) tick();
   endtask

   task automatic test_reset();
      rst = 1; flush = 1; flush_pc = 32'h12345678; branch = 1; branch_addr = 32'h0000_0100;
      tick();
      tick();
      n_vec++;
      if ({inst_req, id_valid, id_adel, id_pc, id_inst} !== {1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
         n_err++;
         $display("FAIL reset_outputs: got req=%b v=%b adel=%b pc=%h inst=%h, required all 0",
                  inst_req, id_valid, id_adel, id_pc, id_inst);
      end
      n_vec++;
      if (inst_addr !== RESET_PC) begin
         n_err++;
         $display("FAIL reset_pc: got %h, required %h", inst_addr, RESET_PC);
      end
      do_reset();
   endtask

   task automatic test_sequential();
      do_reset();
      push_fetch(32'hBFC00000);
      push_fetch(32'hBFC00004);
      push_fetch(32'hBFC00008);
      check_gap = 1;
      run_drain(40);
      check_gap = 0;
   endtask

   task automatic test_branch_pending();
      do_reset();
      push_fetch(32'hBFC00000);
      push_fetch(32'hBFC00004);
      push_fetch(32'hBFC00100);
      wait_id_valid();
      branch = 1; branch_addr = 32'hBFC00100;
      tick();
      branch = 0;
      run_drain(40);
   endtask

   task automatic test_branch_same_cycle();
      do_reset();
      push_fetch(32'hBFC00000);
      push_fetch(32'hBFC00004);
      push_fetch(32'hBFC00100);
      wait_id_valid();
      stall = 1;
      tick();
      tick();
      stall = 0; branch = 1; branch_addr = 32'hBFC00100;
      tick();
      branch = 0;
      run_drain(40);
   endtask

   task automatic test_stall_done();
      logic [65:0] frozen;
      do_reset();
      push_fetch(32'hBFC00000);
      push_fetch(32'hBFC00004);
      tick();
      tick();
      stall = 1;
      frozen = {id_valid, id_adel, id_pc, id_inst};
      for (int i = 0; i < 5; i++) begin
         tick();
         n_vec++;
         if ({inst_req, id_valid, id_adel, id_pc, id_inst} !== {1'b0, frozen}) begin
            n_err++;
            $display("FAIL stall_hold: got req=%b v=%b pc=%h inst=%h, required req=0 v=%b pc=%h inst=%h",
                     inst_req, id_valid, id_pc, id_inst, frozen[65], frozen[63:32], frozen[31:0]);
         end
      end
      stall = 0;
      run_drain(40);
   endtask

   task automatic test_flush_wait();
      do_reset();
      push_fetch(32'hBFC00000);
      exp_addr.push_back(32'hBFC00004);
      push_fetch(32'hBFC00380);
      push_fetch(32'hBFC00384);
      wait_id_valid();
      hold_data = 1; branch = 1; branch_addr = 32'hBFC00100;
      tick();
      branch = 0;
      tick();
      flush = 1; flush_pc = 32'hBFC00380;
      tick();
      flush = 0; hold_data = 0; force_rdata = 1;
      tick();
      force_rdata = 0;
      run_drain(40);
   endtask

   task automatic test_flush_misaligned();
      int n = 0;
      do_reset();
      addr_ok_en = 0; flush = 1; flush_pc = 32'h80000002;
      tick();
      flush = 0; addr_ok_en = 1;
      exp_id.push_back({32'h80000002, 32'h0, 1'b1});
      exp_id.push_back({32'h80000006, 32'h0, 1'b1});
      while (exp_id.size() > 0 && n < 20) begin
         n_vec++;
         if (inst_req !== 1'b0) begin
            n_err++;
            $display("FAIL misaligned_req: got inst_req=%b, required 0", inst_req);
         end
         tick();
         n++;
      end
      run_drain(0);
   endtask

   task automatic test_reset_in_wait();
      do_reset();
      exp_addr.push_back(32'hBFC00000);
      exp_id.push_back({32'hBFC00000, mem_word(32'hBFC00000), 1'b0});
      exp_addr.push_back(32'hBFC00004);
      wait_id_valid();
      hold_data = 1;
      tick();
      rst = 1;
      tick();
      n_vec++;
      if ({inst_req, id_valid, id_adel, id_pc, id_inst, inst_addr} !==
          {1'b0, 1'b0, 1'b0, 32'h0, 32'h0, RESET_PC}) begin
         n_err++;
         $display("FAIL reset_in_wait: got req=%b v=%b adel=%b pc=%h inst=%h addr=%h, required 0/0/0/0/0/%h",
                  inst_req, id_valid, id_adel, id_pc, id_inst, inst_addr, RESET_PC);
      end
      rst = 0; hold_data = 0; pend = 0;
      push_fetch(32'hBFC00000);
      run_drain(40);
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch_pending();
      test_branch_same_cycle();
      test_stall_done();
      test_flush_wait();
      test_flush_misaligned();
      test_reset_in_wait();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
